// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - parametrised VGA raster timing generator
//
// Purpose: pixel-rate divider plus horizontal/vertical counters producing
// registered hsync/vsync/video_on aligned with pixel_x/pixel_y, a pixel
// strobe and combinational line/frame end strobes.
//
// Ports:
//   Clk        in   system clock, rising edge
//   reset      in   synchronous, active-high, dominates en
//   en         in   count enable; low holds all state
//   pixel_x    out  horizontal counter (CW bits)
//   pixel_y    out  vertical counter (CW bits)
//   hsync      out  registered horizontal sync, active level HS_POL
//   vsync      out  registered vertical sync, active level VS_POL
//   video_on   out  registered, high inside the visible area
//   p_tick     out  registered, one Clk when a new pixel_x is presented
//   line_end   out  combinational, last Clk of each line
//   frame_end  out  combinational, last Clk of each frame
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 11
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          p_tick,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A 1-bit divider that never leaves 0 keeps tick permanently high when CLK_DIV is 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_STOP  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_STOP  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] d_q, d_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          p_tick_q;
  logic          tick;

  assign tick = (d_q == D_LAST);

  always_comb begin
    d_d = d_q;
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      d_d = tick ? '0 : d_q + DW'(1);
      if (tick) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end else begin
          h_d = h_q + CW'(1);
        end
      end
    end
  end

  // Sync and blanking decode from the next-state counters so the registered
  // flags line up with pixel_x/pixel_y in the same cycle.
  always_comb begin
    hsync_d    = ((h_d >= HS_START) && (h_d < HS_STOP)) ? HS_POL : ~HS_POL;
    vsync_d    = ((v_d >= VS_START) && (v_d < VS_STOP)) ? VS_POL : ~VS_POL;
    video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      d_q        <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      video_on_q <= 1'b1;
      p_tick_q   <= 1'b0;
    end else begin
      d_q        <= d_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      p_tick_q   <= en & tick;
    end
  end

  assign pixel_x   = h_q;
  assign pixel_y   = v_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign p_tick    = p_tick_q;
  // Masked by reset so the strobes never fire while the counters are being cleared.
  assign line_end  = ~reset & en & tick & (h_q == H_LAST);
  assign frame_end = line_end & (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed bench: default 640x480 timing and a tiny config
module tb_vga_sync_gen;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Default-parameter instance
  logic        rst_a, en_a;
  logic [10:0] px_a, py_a;
  logic        hs_a, vs_a, von_a, pt_a, le_a, fe_a;

  // Small instance: H 4/1/2/1, V 3/1/1/1, CLK_DIV 1, positive syncs
  logic        rst_b, en_b;
  logic [3:0]  px_b, py_b;
  logic        hs_b, vs_b, von_b, pt_b, le_b, fe_b;

  vga_sync_gen dut_a (
    .Clk(Clk), .reset(rst_a), .en(en_a),
    .pixel_x(px_a), .pixel_y(py_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .p_tick(pt_a), .line_end(le_a), .frame_end(fe_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(4)
  ) dut_b (
    .Clk(Clk), .reset(rst_b), .en(en_b),
    .pixel_x(px_b), .pixel_y(py_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .p_tick(pt_b), .line_end(le_b), .frame_end(fe_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int adv;  // enabled Clk edges to advance before checking
    int px;
    int py;
    bit hs;
    bit vs;
    bit von;
    bit pt;
    bit le;
  } vec_t;

  vec_t vecs[13];

  task automatic chk_a(input string tag, input int px, input int py, input bit hs,
                       input bit vs, input bit von, input bit pt, input bit le);
    chk({tag, " pixel_x"},   int'(px_a),  px);
    chk({tag, " pixel_y"},   int'(py_a),  py);
    chk({tag, " hsync"},     int'(hs_a),  int'(hs));
    chk({tag, " vsync"},     int'(vs_a),  int'(vs));
    chk({tag, " video_on"},  int'(von_a), int'(von));
    chk({tag, " p_tick"},    int'(pt_a),  int'(pt));
    chk({tag, " line_end"},  int'(le_a),  int'(le));
    chk({tag, " frame_end"}, int'(fe_a),  0);
  endtask

  // Expected small-config outputs k enabled edges after reset release.
  task automatic chk_b(input string tag, input int k);
    int h, v;
    h = k % 8;
    v = (k / 8) % 6;
    chk({tag, " pixel_x"},   int'(px_b),  h);
    chk({tag, " pixel_y"},   int'(py_b),  v);
    chk({tag, " hsync"},     int'(hs_b),  (h == 5 || h == 6) ? 1 : 0);
    chk({tag, " vsync"},     int'(vs_b),  (v == 4) ? 1 : 0);
    chk({tag, " video_on"},  int'(von_b), (h < 4 && v < 3) ? 1 : 0);
    chk({tag, " p_tick"},    int'(pt_b),  (k >= 1) ? 1 : 0);
    chk({tag, " line_end"},  int'(le_b),  (h == 7) ? 1 : 0);
    chk({tag, " frame_end"}, int'(fe_b),  (h == 7 && v == 5) ? 1 : 0);
  endtask

  initial begin
    int hs_low, von_low, le_cnt, fe_cnt;

    // Cumulative edge count k after release: h = k/2, d = k%2.
    vecs[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // k=1
    vecs[2]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // k=2 first pixel
    vecs[3]  = '{1277, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // k=1279
    vecs[4]  = '{1,    640, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // k=1280 blanking
    vecs[5]  = '{31,   655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // k=1311
    vecs[6]  = '{1,    656, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // k=1312 hsync on
    vecs[7]  = '{191,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // k=1503
    vecs[8]  = '{1,    752, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // k=1504 hsync off
    vecs[9]  = '{94,   799, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // k=1598
    vecs[10] = '{1,    799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};  // k=1599 line_end
    vecs[11] = '{1,    0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // k=1600 wrap
    vecs[12] = '{1,    0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // k=1601

    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    repeat (3) @(negedge Clk);
    chk_a("reset", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    rst_a = 1'b0;
    foreach (vecs[i]) begin
      repeat (vecs[i].adv) @(negedge Clk);
      chk_a($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].hs,
            vecs[i].vs, vecs[i].von, vecs[i].pt, vecs[i].le);
    end

    // Second reset, then en gating at pixel_x=100 (divider at 0).
    rst_a = 1'b1;
    repeat (3) @(negedge Clk);
    chk_a("reset2", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_a = 1'b0;
    repeat (200) @(negedge Clk);
    chk_a("x100", 100, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk_a($sformatf("hold%0d", i), 100, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    en_a = 1'b1;
    @(negedge Clk);
    chk_a("resume1", 100, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    chk_a("resume2", 101, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // One full line from h=101: sync width, blanking width, single line_end.
    hs_low = 0; von_low = 0; le_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      if (le_a) le_cnt++;
      @(negedge Clk);
      if (!hs_a) hs_low++;
      if (!von_a) von_low++;
    end
    chk("line hsync low cycles", hs_low, 192);
    chk("line blank cycles", von_low, 320);
    chk("line_end per line", le_cnt, 1);
    chk("line later pixel_x", int'(px_a), 101);
    chk("line later pixel_y", int'(py_a), 1);

    // Small config: two full frames from reset release.
    rst_a = 1'b1;
    @(negedge Clk);
    chk("small reset line_end", int'(le_b), 0);
    chk("small reset hsync", int'(hs_b), 0);
    chk("small reset vsync", int'(vs_b), 0);
    rst_b = 1'b0;
    fe_cnt = 0;
    for (int k = 0; k < 96; k++) begin
      chk_b($sformatf("small k%0d", k), k);
      if (fe_b) fe_cnt++;
      @(negedge Clk);
    end
    chk("small frame_end count", fe_cnt, 2);

    // Now at k=96 (frame start); move to h=6, v=4 and reset mid-frame.
    repeat (38) @(negedge Clk);
    chk("mid pixel_x", int'(px_b), 6);
    chk("mid pixel_y", int'(py_b), 4);
    rst_b = 1'b1;
    @(negedge Clk);
    chk("mid reset pixel_x", int'(px_b), 0);
    chk("mid reset pixel_y", int'(py_b), 0);
    chk("mid reset hsync", int'(hs_b), 0);
    chk("mid reset vsync", int'(vs_b), 0);
    chk("mid reset video_on", int'(von_b), 1);
    chk("mid reset p_tick", int'(pt_b), 0);
    chk("mid reset line_end", int'(le_b), 0);
    chk("mid reset frame_end", int'(fe_b), 0);
    rst_b = 1'b0;
    for (int k = 0; k < 49; k++) begin
      chk_b($sformatf("after k%0d", k), k);
      @(negedge Clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA raster timing generator. It replaces the fixed 525-line vertical counter with paired horizontal and vertical counters, sync pulse generation, an active-video flag and line/frame strobes. All porch and sync widths and both sync polarities are parameters, and an internal pixel-rate divider derives the pixel cadence from Clk. It feeds the pixel-address logic and the VGA output pins of the video path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CLK_DIV, 2, Clk cycles per pixel (≥1)
- CW, 11, counter width; 2^CW ≥ max(H_TOTAL, V_TOTAL)

Ports:
- Clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; dominates all other inputs
- en  in  1  count enable; when low, all state holds
- pixel_x  out  CW  horizontal counter h
- pixel_y  out  CW  vertical counter v
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- video_on  out  1  registered; high when h < H_ACTIVE and v < V_ACTIVE
- p_tick  out  1  registered; high for one Clk in the first cycle that a new pixel_x value is presented
- line_end  out  1  combinational strobe: en & tick & (h == H_TOTAL-1)
- frame_end  out  1  combinational strobe: line_end & (v == V_TOTAL-1)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is the same sum over the V parameters (default 525).
- Divider d counts 0..CLK_DIV-1. Internal tick = (d == CLK_DIV-1). With CLK_DIV=1, tick is constantly 1.
- On an edge with en=1:
  - d advances, wrapping to 0 when tick is high.
  - If tick is high, h advances. When h == H_TOTAL-1, h wraps to 0 and v advances, wrapping V_TOTAL-1 → 0.
- On an edge with en=0, d, h, v, hsync, vsync, video_on hold. p_tick, line_end and frame_end are 0.
- hsync is at level HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (default 656..751), and ~HS_POL otherwise.
- vsync is at level VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (default 490..491), and ~VS_POL otherwise.
- hsync, vsync and video_on are registered from the next-state counter values, so they are always consistent with pixel_x/pixel_y in the same cycle, with zero skew.
- No other states exist. h and v never leave 0..TOTAL-1.
- Reset values: pixel_x=0, pixel_y=0, d=0, hsync=~HS_POL, vsync=~VS_POL, video_on=1, p_tick=0. line_end and frame_end are 0 while reset is high.

## Timing
- Pixel period is CLK_DIV Clk cycles. With en held high after reset, the first h increment occurs on the CLK_DIV-th edge.
- Line period is H_TOTAL×CLK_DIV Clk cycles; default 1600.
- Frame period is H_TOTAL×V_TOTAL×CLK_DIV Clk cycles; default 840000.
- line_end is high for exactly one Clk per line, in the cycle before h wraps to 0.
- frame_end is high for exactly one Clk per frame, coincident with the line_end of line V_TOTAL-1.
- Reset mid-operation: on the next edge all outputs take their reset values regardless of en.
- Deasserting en mid-pixel freezes d. On re-enable, counting resumes with the remaining divider count and no pixel is lost or duplicated.

## Test plan
- Reset values: hold reset for 3 cycles with en=1 → pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, p_tick=0, line_end=0, frame_end=0.
- Horizontal timing, defaults: hsync=0 exactly while pixel_x ∈ 656..751 (192 Clk); video_on falls at pixel_x=640; line_end pulses once at pixel_x=799; the next pixel_x is 0 with pixel_y=1.
- Full frame, defaults: vsync=0 only for pixel_y 490..491; pixel_y wraps 524→0; frame_end asserts exactly once per 840000 Clk, for one cycle.
- en gating: drop en for 10 cycles at pixel_x=100 → all outputs frozen, p_tick=0. Resume → pixel_x=101 arrives after the remaining divider count.
- Reset mid-frame: assert reset at pixel_x=700, pixel_y=491 → next cycle shows all reset values, and the subsequent frame timing is identical to the post-power-up case.
- Small config: H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1 → H_TOTAL=8, V_TOTAL=6; hsync high at h=5,6; vsync high at v=4; frame_end every 48 Clk; p_tick high every enabled cycle.
